// File: rtl/avst_latency_fifo.sv
// avst_latency_fifo: show-ahead FIFO with an Avalon-ST sink that honours a
// configurable ready latency through credit accounting, and a latency-0 source.
// Optional packet sideband (sop/eop per entry plus a stored-packet count) is
// enabled by defining AVST_LATENCY_FIFO_PKT_EN.
module avst_latency_fifo #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned READY_LATENCY = 3,
  parameter int unsigned ALMOST_FULL   = 12,
  parameter int unsigned ALMOST_EMPTY  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W-1:0]      snk_data_i,
  input  logic                   snk_valid_i,
  output logic                   snk_ready_o,
`ifdef AVST_LATENCY_FIFO_PKT_EN
  input  logic                   snk_sop_i,
  input  logic                   snk_eop_i,
  output logic                   src_sop_o,
  output logic                   src_eop_o,
  output logic [$clog2(DEPTH):0] pkt_cnt_o,
`endif
  output logic [DATA_W-1:0]      src_data_o,
  output logic                   src_valid_o,
  input  logic                   src_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   ovf_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = PW + 4;
`ifdef AVST_LATENCY_FIFO_PKT_EN
  localparam int unsigned EW = DATA_W + 2;
`else
  localparam int unsigned EW = DATA_W;
`endif

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_snk_ready;
  logic          r_src_valid;
  logic          r_af;
  logic          r_ae;
  logic          r_ovf;
  logic [EW-1:0] r_mem [DEPTH];

  logic          w_grant;
  logic [SW-1:0] w_pend_next;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_level_next;
  logic [SW-1:0] w_credit;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

  // Ready history: the grant for this cycle is the ready issued READY_LATENCY cycles ago.
  if (READY_LATENCY == 0) begin : g_rl0
    assign w_grant     = r_snk_ready;
    assign w_pend_next = '0;
  end else begin : g_rl
    logic [READY_LATENCY-1:0] r_rdy_hist;
    logic [READY_LATENCY-1:0] w_hist_next;

    if (READY_LATENCY == 1) begin : g_one
      assign w_hist_next = r_snk_ready;
    end else begin : g_many
      assign w_hist_next = {r_rdy_hist[READY_LATENCY-2:0], r_snk_ready};
    end

    assign w_grant = r_rdy_hist[READY_LATENCY-1];

    // Count readies still outstanding after this edge (credits the source may yet use).
    always_comb begin
      w_pend_next = '0;
      for (int i = 0; i < READY_LATENCY; i++) begin
        w_pend_next = w_pend_next + SW'(w_hist_next[i]);
      end
    end

    // Shift the issued ready into the history.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_rdy_hist <= '0;
      end else begin
        r_rdy_hist <= w_hist_next;
      end
    end
  end

`ifdef AVST_LATENCY_FIFO_PKT_EN
  assign w_wr_entry = {snk_sop_i, snk_eop_i, snk_data_i};
`else
  assign w_wr_entry = snk_data_i;
`endif

  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = ~w_empty & src_ready_i;
  // A full FIFO only takes a beat when the head leaves at the same edge.
  assign w_push  = snk_valid_i & w_grant & (~w_full | w_pop);
  assign w_drop  = snk_valid_i & ~w_push;

  assign w_level_next = r_level + PW'(w_push) - PW'(w_pop);
  // Pops are deliberately left out so a read frees credit one cycle later.
  assign w_credit     = SW'(r_level) + SW'(w_push) + w_pend_next;

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
    end
  end

  // Pointers, occupancy, flags and sink ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_snk_ready <= 1'b0;
      r_src_valid <= 1'b0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_ovf       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level     <= w_level_next;
      r_snk_ready <= (w_credit < SW'(DEPTH));
      r_src_valid <= (w_level_next != '0);
      r_af        <= (w_level_next >= PW'(ALMOST_FULL));
      r_ae        <= (w_level_next <= PW'(ALMOST_EMPTY));
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef AVST_LATENCY_FIFO_PKT_EN
  logic [PW-1:0] r_pkt_cnt;

  // Stored packets: entries carrying eop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pkt_cnt <= '0;
    end else begin
      r_pkt_cnt <= r_pkt_cnt + PW'(w_push & snk_eop_i) - PW'(w_pop & w_head[DATA_W]);
    end
  end

  assign src_sop_o = w_head[DATA_W+1];
  assign src_eop_o = w_head[DATA_W];
  assign pkt_cnt_o = r_pkt_cnt;
`endif

  assign snk_ready_o    = r_snk_ready;
  assign src_data_o     = w_head[DATA_W-1:0];
  assign src_valid_o    = r_src_valid;
  assign level_o        = r_level;
  assign almost_full_o  = r_af;
  assign almost_empty_o = r_ae;
  assign ovf_err_o      = r_ovf;

endmodule

// File: tb/tb_avst_latency_fifo.sv
// Testbench for avst_latency_fifo: a hand-computed vector table, then
// queue-based reference model runs (fill, mid-stream reset, random, wrap,
// and packet sideband when AVST_LATENCY_FIFO_PKT_EN is defined).
module tb_avst_latency_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic        d_ready = 1'b0;
  logic [31:0] s_data = '0;

  logic        a_ready, a_vld, a_af, a_ae, a_ovf;
  logic [31:0] a_data;
  logic [4:0]  a_lvl;
  logic        b_ready, b_vld, b_af, b_ae, b_ovf;
  logic [31:0] b_data;
  logic [2:0]  b_lvl;
`ifdef AVST_LATENCY_FIFO_PKT_EN
  logic        a_sop, a_eop, b_sop, b_eop;
  logic [4:0]  a_pkt;
  logic [2:0]  b_pkt;
`endif

  avst_latency_fifo #(.DATA_W(32), .DEPTH(16), .READY_LATENCY(3),
                      .ALMOST_FULL(12), .ALMOST_EMPTY(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .snk_data_i(s_data), .snk_valid_i(s_valid),
    .snk_ready_o(a_ready),
`ifdef AVST_LATENCY_FIFO_PKT_EN
    .snk_sop_i(s_sop), .snk_eop_i(s_eop), .src_sop_o(a_sop), .src_eop_o(a_eop),
    .pkt_cnt_o(a_pkt),
`endif
    .src_data_o(a_data), .src_valid_o(a_vld), .src_ready_i(d_ready),
    .level_o(a_lvl), .almost_full_o(a_af), .almost_empty_o(a_ae), .ovf_err_o(a_ovf));

  avst_latency_fifo #(.DATA_W(32), .DEPTH(4), .READY_LATENCY(3),
                      .ALMOST_FULL(3), .ALMOST_EMPTY(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .snk_data_i(s_data), .snk_valid_i(s_valid),
    .snk_ready_o(b_ready),
`ifdef AVST_LATENCY_FIFO_PKT_EN
    .snk_sop_i(s_sop), .snk_eop_i(s_eop), .src_sop_o(b_sop), .src_eop_o(b_eop),
    .pkt_cnt_o(b_pkt),
`endif
    .src_data_o(b_data), .src_valid_o(b_vld), .src_ready_i(d_ready),
    .level_o(b_lvl), .almost_full_o(b_af), .almost_empty_o(b_ae), .ovf_err_o(b_ovf));

  // Observed outputs of the instance under test.
  bit          sel = 1'b0;
  logic        o_ready, o_vld, o_sop, o_eop, o_af, o_ae, o_ovf;
  logic [31:0] o_data, o_lvl, o_pkt;

  always_comb begin
    o_sop = 1'b0;
    o_eop = 1'b0;
    o_pkt = '0;
    if (!sel) begin
      o_ready = a_ready; o_vld = a_vld; o_af = a_af; o_ae = a_ae; o_ovf = a_ovf;
      o_data = a_data; o_lvl = 32'(a_lvl);
`ifdef AVST_LATENCY_FIFO_PKT_EN
      o_sop = a_sop; o_eop = a_eop; o_pkt = 32'(a_pkt);
`endif
    end else begin
      o_ready = b_ready; o_vld = b_vld; o_af = b_af; o_ae = b_ae; o_ovf = b_ovf;
      o_data = b_data; o_lvl = 32'(b_lvl);
`ifdef AVST_LATENCY_FIFO_PKT_EN
      o_sop = b_sop; o_eop = b_eop; o_pkt = 32'(b_pkt);
`endif
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, issued readies as a queue (oldest first).
  int          m_depth, m_rl, m_af, m_ae;
  logic [33:0] m_q[$];
  bit          m_hist[$];
  bit          m_ready, m_ovf;
  bit          m_known = 1'b0;
  bit          src_seen[$];     // readies the source has observed (oldest first)
  logic [33:0] popped[$];       // beats seen leaving the DUT

  function automatic bit grant_seen();
    if (m_rl == 0) return o_ready;
    return src_seen[0];
  endfunction

  task automatic compare_outputs();
    int sz;
    sz = m_q.size();
    check("snk_ready", 64'(o_ready), 64'(m_ready));
    check("level", 64'(o_lvl), 64'(sz));
    check("src_valid", 64'(o_vld), 64'(sz != 0));
    check("almost_full", 64'(o_af), 64'(sz >= m_af));
    check("almost_empty", 64'(o_ae), 64'(sz <= m_ae));
    check("ovf_err", 64'(o_ovf), 64'(m_ovf));
    if (sz != 0) begin
      check("src_data", 64'(o_data), 64'(m_q[0][31:0]));
`ifdef AVST_LATENCY_FIFO_PKT_EN
      check("src_sop", 64'(o_sop), 64'(m_q[0][33]));
      check("src_eop", 64'(o_eop), 64'(m_q[0][32]));
`endif
    end
`ifdef AVST_LATENCY_FIFO_PKT_EN
    begin
      int np;
      np = 0;
      foreach (m_q[i]) np += int'(m_q[i][32]);
      check("pkt_cnt", 64'(o_pkt), 64'(np));
    end
`endif
  endtask

  // One clock cycle: check, drive, advance model, wait for the edge.
  task automatic step(input bit r, input bit v, input logic [31:0] d,
                      input bit sop, input bit eop, input bit sr);
    bit g, pop, push;
    int outst, credit;
    if (m_known) compare_outputs();
    if (!r && o_vld === 1'b1 && sr) popped.push_back({o_sop, o_eop, o_data});
    rst = r; s_valid = v; s_data = d; s_sop = sop; s_eop = eop; d_ready = sr;
    if (r) begin
      m_q.delete();
      m_hist.delete();
      for (int i = 0; i < m_rl; i++) m_hist.push_back(1'b0);
      m_ready = 1'b0;
      m_ovf   = 1'b0;
      m_known = 1'b1;
    end else begin
      g     = (m_rl == 0) ? m_ready : m_hist[0];
      pop   = (m_q.size() != 0) && sr;
      push  = v && g && ((m_q.size() < m_depth) || pop);
      outst = 0;
      if (m_rl > 0) begin
        for (int i = 1; i < m_rl; i++) outst += int'(m_hist[i]);
        outst += int'(m_ready);
      end
      credit = m_q.size() + int'(push) + outst;
      if (v && !push) m_ovf = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({sop, eop, d});
      if (m_rl > 0) begin
        void'(m_hist.pop_front());
        m_hist.push_back(m_ready);
      end
      m_ready = (credit < m_depth);
    end
    if (m_rl > 0) begin
      src_seen.push_back(o_ready === 1'b1);
      void'(src_seen.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_phase(input bit s);
    sel = s;
    if (!s) begin m_depth = 16; m_rl = 3; m_af = 12; m_ae = 2; end
    else    begin m_depth = 4;  m_rl = 3; m_af = 3;  m_ae = 1; end
    m_known = 1'b0;
    src_seen.delete();
    for (int i = 0; i < m_rl; i++) src_seen.push_back(1'b0);
    popped.delete();
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          rst;
    bit          vld;
    logic [31:0] data;
    bit          srdy;
    bit          chk;
    bit          e_rdy;
    bit          e_vld;
    int          e_lvl;
    logic [31:0] e_data;
    bit          e_ovf;
  } vec_t;

  vec_t        tbl[16];
  bit          v_b, sr_b, r_b;
  int          nxt, acc;
  logic [33:0] beats[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Defaults build, RL=3: ready rises in cycle 5, beat in cycle 7 is a violation,
    // beat in cycle 8 (granted by cycle-5 ready) is visible in cycle 9.
    //           rst vld data          srdy chk rdy vld lvl e_data        ovf
    tbl[0]  = '{1, 0, 32'h0,         0,   0,  0,  0,  0,  32'h0,        0};
    tbl[1]  = '{1, 0, 32'h0,         0,   1,  0,  0,  0,  32'h0,        0};
    tbl[2]  = '{1, 0, 32'h0,         0,   1,  0,  0,  0,  32'h0,        0};
    tbl[3]  = '{1, 0, 32'h0,         0,   1,  0,  0,  0,  32'h0,        0};
    tbl[4]  = '{0, 0, 32'h0,         0,   1,  0,  0,  0,  32'h0,        0};
    tbl[5]  = '{0, 0, 32'h0,         0,   1,  1,  0,  0,  32'h0,        0};
    tbl[6]  = '{0, 0, 32'h0,         0,   1,  1,  0,  0,  32'h0,        0};
    tbl[7]  = '{0, 1, 32'h11111111,  0,   1,  1,  0,  0,  32'h0,        0};
    tbl[8]  = '{0, 1, 32'hA5A5A5A5,  0,   1,  1,  0,  0,  32'h0,        1};
    tbl[9]  = '{0, 1, 32'h00000002,  0,   1,  1,  1,  1,  32'hA5A5A5A5, 1};
    tbl[10] = '{0, 0, 32'h0,         1,   1,  1,  1,  2,  32'hA5A5A5A5, 1};
    tbl[11] = '{0, 1, 32'h00000003,  1,   1,  1,  1,  1,  32'h00000002, 1};
    tbl[12] = '{0, 0, 32'h0,         1,   1,  1,  1,  1,  32'h00000003, 1};
    tbl[13] = '{1, 0, 32'h0,         0,   1,  1,  0,  0,  32'h0,        1};
    tbl[14] = '{0, 0, 32'h0,         0,   1,  0,  0,  0,  32'h0,        0};
    tbl[15] = '{0, 0, 32'h0,         0,   1,  1,  0,  0,  32'h0,        0};

    sel = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (tbl[k].chk) begin
        check($sformatf("tbl%0d_ready", k), 64'(a_ready), 64'(tbl[k].e_rdy));
        check($sformatf("tbl%0d_valid", k), 64'(a_vld), 64'(tbl[k].e_vld));
        check($sformatf("tbl%0d_level", k), 64'(a_lvl), 64'(tbl[k].e_lvl));
        check($sformatf("tbl%0d_ovf", k), 64'(a_ovf), 64'(tbl[k].e_ovf));
        check($sformatf("tbl%0d_aempty", k), 64'(a_ae), 64'(tbl[k].e_lvl <= 2));
        if (tbl[k].e_vld)
          check($sformatf("tbl%0d_data", k), 64'(a_data), 64'(tbl[k].e_data));
      end
      rst = tbl[k].rst; s_valid = tbl[k].vld; s_data = tbl[k].data; d_ready = tbl[k].srdy;
      @(posedge clk);
      @(negedge clk);
    end

    // Fill: compliant source, no reads -> exactly DEPTH beats, no overflow.
    start_phase(1'b0);
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      v_b = grant_seen();
      step(1'b0, v_b, 32'(c), 1'b0, 1'b0, 1'b0);
      acc += int'(v_b);
    end
    check("fill_accepted", 64'(acc), 64'(16));
    check("fill_level", 64'(o_lvl), 64'(16));
    check("fill_ready_low", 64'(o_ready), 64'(0));
    check("fill_ovf", 64'(o_ovf), 64'(0));
    check("fill_almost_full", 64'(o_af), 64'(1));

    // Mid-stream reset at level 7, then a beat on a pre-reset ready is dropped.
    start_phase(1'b0);
    for (int c = 0; c < 60 && m_q.size() < 7; c++) begin
      v_b = grant_seen();
      step(1'b0, v_b, 32'(100 + c), 1'b0, 1'b0, 1'b0);
    end
    check("midrst_level_before", 64'(o_lvl), 64'(7));
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("midrst_level", 64'(o_lvl), 64'(0));
    check("midrst_valid", 64'(o_vld), 64'(0));
    check("midrst_ready", 64'(o_ready), 64'(0));
    step(1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0);
    check("postrst_ready", 64'(o_ready), 64'(1));
    check("postrst_ovf", 64'(o_ovf), 64'(1));
    check("postrst_level", 64'(o_lvl), 64'(0));
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Random traffic with protocol violations and occasional resets.
    for (int c = 0; c < 300; c++) begin
      r_b  = ($urandom % 64) == 0;
      v_b  = ($urandom % 2) != 0;
      sr_b = ($urandom % 3) != 0;
      step(r_b, v_b, $urandom, 1'(($urandom % 4) == 0), 1'(($urandom % 3) == 0), sr_b);
    end

    // Wrap and ordering on DEPTH=4: 0..99 with random consumer stalls.
    start_phase(1'b1);
    nxt = 0;
    for (int c = 0; c < 3000 && popped.size() < 100; c++) begin
      v_b  = grant_seen() && (nxt < 100) && (($urandom % 4) != 0);
      sr_b = ($urandom % 2) != 0;
      step(1'b0, v_b, 32'(nxt), 1'b0, 1'b0, sr_b);
      if (v_b) nxt++;
    end
    check("wrap_count", 64'(popped.size()), 64'(100));
    for (int i = 0; i < popped.size() && i < 100; i++)
      check($sformatf("wrap_data%0d", i), 64'(popped[i][31:0]), 64'(i));
    check("wrap_ovf", 64'(o_ovf), 64'(0));

`ifdef AVST_LATENCY_FIFO_PKT_EN
    // Packets of 1, 2 and 5 beats: framing reproduced, packet count 3 then 0.
    start_phase(1'b0);
    beats.delete();
    begin
      int lens[3];
      lens[0] = 1; lens[1] = 2; lens[2] = 5;
      for (int p = 0; p < 3; p++)
        for (int b = 0; b < lens[p]; b++)
          beats.push_back({1'(b == 0), 1'(b == lens[p] - 1), 32'(p * 16 + b)});
    end
    nxt = 0;
    for (int c = 0; c < 200 && nxt < 8; c++) begin
      v_b = grant_seen();
      if (v_b) begin
        step(1'b0, 1'b1, beats[nxt][31:0], beats[nxt][33], beats[nxt][32], 1'b0);
        nxt++;
      end else begin
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
    end
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("pkt_cnt_peak", 64'(o_pkt), 64'(3));
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("pkt_beats", 64'(popped.size()), 64'(8));
    for (int i = 0; i < popped.size() && i < 8; i++)
      check($sformatf("pkt_beat%0d", i), 64'(popped[i]), 64'(beats[i]));
    check("pkt_cnt_end", 64'(o_pkt), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
